// File: rtl/axis_head_splitter.sv
// Splits each AXI-stream packet into a head packet (first head_len beats)
// and a body packet (the rest), each behind a one-entry output register.
module axis_head_splitter #(
  parameter int    DSIZE           = 8,
  parameter string KEEP_SHORT_FLAG = "ON"
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [15:0]      head_len,
  input  logic [DSIZE-1:0] s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [DSIZE-1:0] head_tdata,
  output logic             head_tvalid,
  output logic             head_tlast,
  input  logic             head_tready,
  output logic [DSIZE-1:0] body_tdata,
  output logic             body_tvalid,
  output logic             body_tlast,
  input  logic             body_tready,
  output logic             short_pkt
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  localparam bit SHORT_EN = (KEEP_SHORT_FLAG == "ON");

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx, len_q, len_nx, cur_len, beat_idx;
  logic        head_free, body_free, sel_body, accept;
  logic        load_head, load_body, tlast_nx, short_nx;

  assign head_free = !head_tvalid || head_tready;
  assign body_free = !body_tvalid || body_tready;
  // In IDLE the live head_len decides the target, since it is latched on this beat
  assign sel_body  = (state == BODY) || ((state == IDLE) && (head_len == 16'd0));
  assign cur_len   = (state == IDLE) ? head_len : len_q;
  assign beat_idx  = (state == IDLE) ? 16'd1 : cnt + 16'd1;
  assign s_tready  = aresetn && (sel_body ? body_free : head_free);
  assign accept    = s_tvalid && s_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt   <= 16'd0;
      len_q <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      len_q <= len_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    len_nx    = len_q;
    load_head = 1'b0;
    load_body = 1'b0;
    tlast_nx  = s_tlast;
    short_nx  = 1'b0;
    if (accept) begin
      if (state == IDLE) len_nx = head_len;
      if (sel_body) begin
        load_body = 1'b1;
        tlast_nx  = s_tlast;
        cnt_nx    = 16'd0;
        state_nx  = s_tlast ? IDLE : BODY;
      end else begin
        load_head = 1'b1;
        tlast_nx  = (beat_idx == cur_len) || s_tlast;
        cnt_nx    = beat_idx;
        if (s_tlast) begin
          short_nx = 1'b1;
          cnt_nx   = 16'd0;
          state_nx = IDLE;
        end else if (beat_idx == cur_len) begin
          state_nx = BODY;
        end else begin
          state_nx = HEAD;
        end
      end
    end
  end

  // A register only reloads when free, so a held beat stays put until taken
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head_tdata  <= '0;
      head_tvalid <= 1'b0;
      head_tlast  <= 1'b0;
      body_tdata  <= '0;
      body_tvalid <= 1'b0;
      body_tlast  <= 1'b0;
      short_pkt   <= 1'b0;
    end else begin
      if (load_head) begin
        head_tdata  <= s_tdata;
        head_tvalid <= 1'b1;
        head_tlast  <= tlast_nx;
      end else if (head_tready) begin
        head_tvalid <= 1'b0;
      end
      if (load_body) begin
        body_tdata  <= s_tdata;
        body_tvalid <= 1'b1;
        body_tlast  <= tlast_nx;
      end else if (body_tready) begin
        body_tvalid <= 1'b0;
      end
      short_pkt <= SHORT_EN && short_nx;
    end
  end

endmodule

// File: tb/tb_axis_head_splitter.sv
// Self-checking bench: random packets are split by a queue-based reference
// model and compared with the head/body beats and short_pkt pulses observed.
module tb_axis_head_splitter;

  localparam int DW = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [15:0]   head_len;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] head_tdata, body_tdata;
  logic          head_tvalid, head_tlast, head_tready;
  logic          body_tvalid, body_tlast, body_tready;
  logic          short_pkt;

  logic [DW:0]   exp_head[$], exp_body[$], obs_head[$], obs_body[$];
  logic [DW-1:0] pkt_q[$];
  int            exp_short, short_cnt, stall_cycles;
  int            checks = 0, failures = 0;
  bit            rand_ready = 1'b0;
  bit            send_done;

  axis_head_splitter #(.DSIZE(DW), .KEEP_SHORT_FLAG("ON")) dut (
    .aclk(aclk), .aresetn(aresetn), .head_len(head_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .head_tdata(head_tdata), .head_tvalid(head_tvalid), .head_tlast(head_tlast),
    .head_tready(head_tready),
    .body_tdata(body_tdata), .body_tvalid(body_tvalid), .body_tlast(body_tlast),
    .body_tready(body_tready),
    .short_pkt(short_pkt)
  );

  always #5 aclk = ~aclk;

  // Inputs move 1ns after posedge, so the negedge sees what the next posedge will use
  always @(negedge aclk) begin
    if (aresetn) begin
      if (head_tvalid && head_tready) obs_head.push_back({head_tlast, head_tdata});
      if (body_tvalid && body_tready) obs_body.push_back({body_tlast, body_tdata});
      if (short_pkt) short_cnt++;
    end
  end

  always @(posedge aclk) begin
    #1;
    if (rand_ready) begin
      head_tready = ($urandom_range(0, 3) != 0);
      body_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic make_packet(input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(DW'($urandom));
  endtask

  // Reference split: first L beats are head (L==0 means none), the rest body
  task automatic build_expected(input int L);
    int n = pkt_q.size();
    exp_head.delete(); exp_body.delete();
    for (int i = 0; i < n; i++) begin
      if (L != 0 && i < L) exp_head.push_back({(i == L - 1) || (i == n - 1), pkt_q[i]});
      else                 exp_body.push_back({i == n - 1, pkt_q[i]});
    end
    exp_short = (L != 0 && n <= L) ? 1 : 0;
    obs_head.delete(); obs_body.delete(); short_cnt = 0;
  endtask

  task automatic send_packet(input int hl, input int hl_late, input int gaps);
    int n = pkt_q.size();
    int waitc;
    stall_cycles = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps > 0) begin
        int g = $urandom_range(0, gaps);
        s_tvalid = 1'b0;
        repeat (g) begin @(posedge aclk); #1; end
      end
      s_tvalid = 1'b1;
      s_tdata  = pkt_q[i];
      s_tlast  = (i == n - 1);
      if (i == 0) head_len = 16'(hl);
      waitc = 0;
      @(negedge aclk);
      while (!s_tready && waitc < 400) begin
        waitc++; stall_cycles++;
        @(negedge aclk);
      end
      if (!s_tready) begin
        checks++; failures++;
        $display("[TB] FAIL handshake_timeout: beat %0d not accepted, s_tready=%b required 1", i, s_tready);
        s_tvalid = 1'b0;
        return;
      end
      @(posedge aclk); #1;
      if (i == 0) head_len = 16'(hl_late);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    rand_ready  = 1'b0;
    head_tready = 1'b1;
    body_tready = 1'b1;
    while ((obs_head.size() < exp_head.size() || obs_body.size() < exp_body.size()) && k < 300) begin
      @(posedge aclk); #1; k++;
    end
    repeat (3) begin @(posedge aclk); #1; end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_tvalid = 1'b1; s_tdata = 8'h5A; s_tlast = 1'b0; head_len = 16'd3;
    head_tready = 1'b1; body_tready = 1'b1;
    #23;
    checks++;
    if ({head_tvalid, body_tvalid, head_tlast, body_tlast, short_pkt, head_tdata, body_tdata} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: hv=%b bv=%b hl=%b bl=%b sp=%b hd=%h bd=%h required all 0",
               head_tvalid, body_tvalid, head_tlast, body_tlast, short_pkt, head_tdata, body_tdata);
    end
    checks++;
    if (s_tready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_s_tready: got %b required 0", s_tready);
    end
    s_tvalid = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    bit bad;
    head_tready = 1'b1; body_tready = 1'b1;
    make_packet(8); build_expected(3);
    send_packet(3, 3, 0);
    checks++;
    if (stall_cycles !== 0) begin
      failures++; $display("[TB] FAIL basic_no_stall: stall cycles %0d required 0", stall_cycles);
    end
    drain();
    checks++; bad = (obs_head.size() != exp_head.size());
    if (!bad) foreach (exp_head[i]) if (obs_head[i] !== exp_head[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL basic_head: got %0d beats required %0d (or data/last differ)", obs_head.size(), exp_head.size()); end
    checks++; bad = (obs_body.size() != exp_body.size());
    if (!bad) foreach (exp_body[i]) if (obs_body[i] !== exp_body[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL basic_body: got %0d beats required %0d (or data/last differ)", obs_body.size(), exp_body.size()); end
    checks++;
    if (short_cnt !== exp_short) begin failures++; $display("[TB] FAIL basic_short: got %0d pulses required %0d", short_cnt, exp_short); end
  endtask

  task automatic test_short();
    bit bad;
    head_tready = 1'b1; body_tready = 1'b1;
    make_packet(4); build_expected(4);
    send_packet(4, 4, 0);
    @(negedge aclk);
    checks++;
    if (short_pkt !== 1'b1) begin failures++; $display("[TB] FAIL short_timing: short_pkt=%b required 1 one cycle after last beat", short_pkt); end
    @(negedge aclk);
    checks++;
    if (short_pkt !== 1'b0) begin failures++; $display("[TB] FAIL short_width: short_pkt=%b required 0 on second cycle", short_pkt); end
    drain();
    checks++; bad = (obs_head.size() != exp_head.size());
    if (!bad) foreach (exp_head[i]) if (obs_head[i] !== exp_head[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL short_head: got %0d beats required %0d (or data/last differ)", obs_head.size(), exp_head.size()); end
    checks++;
    if (obs_body.size() !== 0 || short_cnt !== 1) begin
      failures++; $display("[TB] FAIL short_nobody: body beats %0d pulses %0d required 0 and 1", obs_body.size(), short_cnt);
    end
  endtask

  task automatic test_zero_len();
    bit bad;
    head_tready = 1'b1; body_tready = 1'b1;
    make_packet(5); build_expected(0);
    send_packet(0, 0, 1);
    drain();
    checks++;
    if (obs_head.size() !== 0) begin failures++; $display("[TB] FAIL zero_head: got %0d head beats required 0", obs_head.size()); end
    checks++; bad = (obs_body.size() != exp_body.size());
    if (!bad) foreach (exp_body[i]) if (obs_body[i] !== exp_body[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL zero_body: got %0d beats required %0d (or data/last differ)", obs_body.size(), exp_body.size()); end
    checks++;
    if (short_cnt !== 0) begin failures++; $display("[TB] FAIL zero_short: got %0d pulses required 0", short_cnt); end
  endtask

  task automatic test_backpressure();
    bit bad, hold_bad;
    int k;
    rand_ready = 1'b0; head_tready = 1'b1; body_tready = 1'b0;
    make_packet(6); build_expected(2);
    send_done = 1'b0;
    fork
      begin send_packet(2, 2, 0); send_done = 1'b1; end
    join_none
    hold_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (c >= 4 && (s_tready !== 1'b0 || body_tvalid !== 1'b1 ||
                     {body_tlast, body_tdata} !== exp_body[0])) hold_bad = 1'b1;
    end
    checks++;
    if (hold_bad) begin
      failures++;
      $display("[TB] FAIL bp_hold: s_tready=%b bv=%b body=%h required 0,1,%h", s_tready, body_tvalid, {body_tlast, body_tdata}, exp_body[0]);
    end
    checks++;
    if (obs_head.size() !== 2) begin failures++; $display("[TB] FAIL bp_head_done: got %0d head beats required 2", obs_head.size()); end
    @(posedge aclk); #1; body_tready = 1'b1;
    k = 0;
    while (!send_done && k < 200) begin @(posedge aclk); #1; k++; end
    drain();
    checks++; bad = (obs_body.size() != exp_body.size());
    if (!bad) foreach (exp_body[i]) if (obs_body[i] !== exp_body[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL bp_body: got %0d beats required %0d (or data/last differ)", obs_body.size(), exp_body.size()); end
  endtask

  task automatic test_len_change();
    bit bad;
    head_tready = 1'b1; body_tready = 1'b1;
    make_packet(7); build_expected(2);
    send_packet(2, 5, 0);
    drain();
    checks++; bad = (obs_head.size() != exp_head.size());
    if (!bad) foreach (exp_head[i]) if (obs_head[i] !== exp_head[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL lenchg_head1: got %0d beats required %0d (or data/last differ)", obs_head.size(), exp_head.size()); end
    make_packet(7); build_expected(5);
    send_packet(5, 5, 0);
    drain();
    checks++; bad = (obs_head.size() != exp_head.size());
    if (!bad) foreach (exp_head[i]) if (obs_head[i] !== exp_head[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL lenchg_head2: got %0d beats required %0d (or data/last differ)", obs_head.size(), exp_head.size()); end
    checks++; bad = (obs_body.size() != exp_body.size());
    if (!bad) foreach (exp_body[i]) if (obs_body[i] !== exp_body[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL lenchg_body2: got %0d beats required %0d (or data/last differ)", obs_body.size(), exp_body.size()); end
  endtask

  task automatic test_reset_mid();
    bit bad;
    rand_ready = 1'b0; head_tready = 1'b1; body_tready = 1'b0;
    head_len = 16'd2; s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'h11;
    repeat (6) begin @(posedge aclk); #1; s_tdata = s_tdata + 8'd1; end
    @(negedge aclk);
    checks++;
    if (s_tready !== 1'b0 || body_tvalid !== 1'b1) begin
      failures++; $display("[TB] FAIL rstmid_stalled: s_tready=%b bv=%b required 0 and 1", s_tready, body_tvalid);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({head_tvalid, body_tvalid, short_pkt, s_tready} !== 4'b0) begin
      failures++; $display("[TB] FAIL rstmid_clear: hv=%b bv=%b sp=%b rdy=%b required all 0", head_tvalid, body_tvalid, short_pkt, s_tready);
    end
    s_tvalid = 1'b0;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    head_tready = 1'b1; body_tready = 1'b1;
    make_packet(5); build_expected(1);
    send_packet(1, 1, 0);
    drain();
    checks++; bad = (obs_head.size() != exp_head.size());
    if (!bad) foreach (exp_head[i]) if (obs_head[i] !== exp_head[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL rstmid_head: got %0d beats required %0d (or data/last differ)", obs_head.size(), exp_head.size()); end
    checks++; bad = (obs_body.size() != exp_body.size());
    if (!bad) foreach (exp_body[i]) if (obs_body[i] !== exp_body[i]) bad = 1;
    if (bad) begin failures++; $display("[TB] FAIL rstmid_body: got %0d beats required %0d (or data/last differ)", obs_body.size(), exp_body.size()); end
  endtask

  task automatic test_random();
    bit bad;
    int n, hl, r;
    for (int p = 0; p < 25; p++) begin
      n = $urandom_range(1, 10);
      r = $urandom_range(0, 9);
      hl = (r == 0) ? 0 : (r == 1) ? 16'hFFFF : $urandom_range(1, 12);
      make_packet(n); build_expected(hl);
      rand_ready = 1'b1;
      send_packet(hl, $urandom_range(0, 15), 3);
      drain();
      checks++; bad = (obs_head.size() != exp_head.size());
      if (!bad) foreach (exp_head[i]) if (obs_head[i] !== exp_head[i]) bad = 1;
      if (bad) begin failures++; $display("[TB] FAIL rand_head p%0d n=%0d L=%0d: got %0d beats required %0d (or data/last differ)", p, n, hl, obs_head.size(), exp_head.size()); end
      checks++; bad = (obs_body.size() != exp_body.size());
      if (!bad) foreach (exp_body[i]) if (obs_body[i] !== exp_body[i]) bad = 1;
      if (bad) begin failures++; $display("[TB] FAIL rand_body p%0d n=%0d L=%0d: got %0d beats required %0d (or data/last differ)", p, n, hl, obs_body.size(), exp_body.size()); end
      checks++;
      if (short_cnt !== exp_short) begin failures++; $display("[TB] FAIL rand_short p%0d: got %0d pulses required %0d", p, short_cnt, exp_short); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_zero_len();
    test_backpressure();
    test_len_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
